// File: rtl/pulse_monitor_pkg.sv
// Shared types and constants for the pulse_monitor slice.
// err_count width is used only when PULSE_MONITOR_STATS_EN is defined.
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 16;

  // Saturating increment for the error statistics counter.
  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] value);
    if (value == {ERR_CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pulse_interval_cnt.sv
// Saturating interval counter: restarts at 1 on each sampled pulse,
// otherwise counts clocks since the last pulse and sticks at all-ones.
module pulse_interval_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Interval counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pulse_in) begin
      cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign sat = (cnt_r == CNT_MAX);

endmodule

// File: rtl/pulse_monitor.sv
// Periodic pulse monitor: measures pulse intervals, locks after LOCK_COUNT in-window
// intervals, flags early/late pulses. Define PULSE_MONITOR_STATS_EN to add err_count.
module pulse_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int PERIOD     = 5,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_in,
`ifdef PULSE_MONITOR_STATS_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic                 locked,
  output logic [CNT_W-1:0]     period,
  output logic                 period_valid,
  output logic                 early_err,
  output logic                 late_err
);

  localparam int GCNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0]  LATE_CNT  = CNT_W'(PERIOD + TOL + 1);
  localparam logic [GCNT_W-1:0] GCNT_LOCK = GCNT_W'(LOCK_COUNT);
  localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);

  logic [CNT_W-1:0]  cnt_s;
  logic              sat_s;
  logic              active_s;
  logic              is_early_s;
  logic              in_window_s;
  logic              late_due_s;
  logic              early_fire_s;
  logic              late_fire_s;
  logic [GCNT_W-1:0] gcnt_inc_s;

  state_t            state_r;
  logic [GCNT_W-1:0] gcnt_r;
  logic              late_flag_r;
  logic              locked_r;
  logic [CNT_W-1:0]  period_r;
  logic              period_valid_r;
  logic              early_err_r;
  logic              late_err_r;

  pulse_interval_cnt #(
    .CNT_W (CNT_W)
  ) u_interval_cnt (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .cnt      (cnt_s),
    .sat      (sat_s)
  );

  // The counter holds the interval length on the cycle its closing pulse is sampled.
  assign active_s     = (state_r != IDLE);
  assign is_early_s   = (cnt_s < WIN_LO);
  assign in_window_s  = !is_early_s && (cnt_s <= WIN_HI);
  assign late_due_s   = (cnt_s == LATE_CNT) && !late_flag_r;
  assign early_fire_s = active_s && pulse_in && is_early_s;
  assign late_fire_s  = active_s && late_due_s;
  assign gcnt_inc_s   = gcnt_r + GCNT_ONE;

  // Lock FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      gcnt_r         <= {GCNT_W{1'b0}};
      late_flag_r    <= 1'b0;
      locked_r       <= 1'b0;
      period_r       <= {CNT_W{1'b0}};
      period_valid_r <= 1'b0;
      early_err_r    <= 1'b0;
      late_err_r     <= 1'b0;
    end else begin
      period_valid_r <= 1'b0;
      early_err_r    <= early_fire_s;
      late_err_r     <= late_fire_s;
      case (state_r)
        IDLE: begin
          if (pulse_in) begin
            state_r     <= ACQUIRE;
            gcnt_r      <= {GCNT_W{1'b0}};
            late_flag_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        ACQUIRE, LOCKED: begin
          if (pulse_in) begin
            period_r       <= cnt_s;
            period_valid_r <= 1'b1;
            late_flag_r    <= 1'b0;
            if (in_window_s) begin
              if ((state_r == LOCKED) || (gcnt_inc_s >= GCNT_LOCK)) begin
                state_r  <= LOCKED;
                locked_r <= 1'b1;
                gcnt_r   <= GCNT_LOCK;
              end else begin
                gcnt_r <= gcnt_inc_s;
              end
            end else begin
              state_r  <= ACQUIRE;
              locked_r <= 1'b0;
              gcnt_r   <= {GCNT_W{1'b0}};
            end
          end else if (sat_s) begin
            // Source has gone quiet for the whole counter range: start over.
            state_r     <= IDLE;
            locked_r    <= 1'b0;
            gcnt_r      <= {GCNT_W{1'b0}};
            late_flag_r <= 1'b0;
          end else if (late_due_s) begin
            state_r     <= ACQUIRE;
            locked_r    <= 1'b0;
            gcnt_r      <= {GCNT_W{1'b0}};
            late_flag_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          locked_r    <= 1'b0;
          gcnt_r      <= {GCNT_W{1'b0}};
          late_flag_r <= 1'b0;
        end
      endcase
    end
  end

  assign locked       = locked_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign early_err    = early_err_r;
  assign late_err     = late_err_r;

`ifdef PULSE_MONITOR_STATS_EN
  logic [ERR_CNT_W-1:0] err_count_r;

  // Saturating count of reported early/late errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else if (early_fire_s || late_fire_s) begin
      err_count_r <= err_sat_inc(err_count_r);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`endif

endmodule
